// File: rtl/tlv5618_driver_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tlv5618_driver_pkg
//  Purpose  : Shared definitions for the TLV5618 serial DAC driver: serial
//             word length, state encoding and TLV5618 control-nibble values.
//  Revision : 1.0  initial release
// ============================================================================
package tlv5618_driver_pkg;

    // The TLV5618 always expects a 16-bit frame: 4 control bits + 12 data bits.
    localparam int c_WORD_W = 16;
    localparam int c_CODE_W = 12;

    // Driver state encoding.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    // Control nibble D15..D12 = {R1, SPD, PWR, R0}.
    // R1/R0 select the target register, SPD picks fast settling, PWR powers down.
    localparam logic [3:0] c_CTRL_DAC_A_FAST = 4'b1100;  // write DAC A, update B from buffer
    localparam logic [3:0] c_CTRL_DAC_B_BUF  = 4'b0100;  // write DAC B and the buffer
    localparam logic [3:0] c_CTRL_BUF_FAST   = 4'b0101;  // write the buffer only
    localparam logic [3:0] c_CTRL_PWR_DOWN   = 4'b0010;  // power-down bit mask

    // Assemble a full serial frame from a control nibble and a 12-bit code.
    function automatic logic [c_WORD_W-1:0] make_word(input logic [3:0]          ctrl,
                                                      input logic [c_CODE_W-1:0] code);
        return {ctrl, code};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tlv5618_clk_div.sv
`default_nettype none
// ============================================================================
//  Module   : tlv5618_clk_div
//  Purpose  : Half-period timer for the DAC serial clock. While enabled it
//             raises o_tick for one cycle every HALF_DIV cycles; the driver
//             toggles dac_clk on each tick.
//  Ports    : clk     system clock
//             rst     synchronous active-high reset
//             i_en    count enable; low holds the counter at zero
//             o_tick  one-cycle pulse at the end of every half period
//  Revision : 1.0  initial release
// ============================================================================
import tlv5618_driver_pkg::*;

module tlv5618_clk_div #(
    parameter int HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_tick
);

    // A one-bit counter is kept even for HALF_DIV == 1; it simply never leaves 0.
    localparam int                 c_CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(HALF_DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;

    // The tick is qualified by i_en so that the cycle the driver leaves IDLE
    // starts a fresh, full-length half period.
    assign o_tick = i_en && (r_cnt == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_en || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tlv5618_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tlv5618_driver
//  Purpose  : Serial-interface driver for the TI TLV5618 dual 12-bit DAC.
//             A 16-bit command/data word accepted on start_flag is shifted
//             MSB-first over CS/SCLK/DIN. The DAC samples DIN on the falling
//             edge of dac_clk, so DIN only changes when dac_clk rises.
//  Ports    : sys_clk            system clock, rising-edge logic
//             sys_rst            synchronous active-high reset
//             parallel_dac_data  word to send, sampled when a start is taken
//             start_flag         start request, honoured only when idle
//             set_done           one-cycle pulse as cs returns high
//             cs                 DAC chip select, active low
//             series_dac_out     serial data to DAC DIN
//             dac_clk            serial clock to DAC SCLK, idles high
//             dac_work_status    high while a transfer is in progress
//  Revision : 1.0  initial release
// ============================================================================
import tlv5618_driver_pkg::*;

module tlv5618_driver #(
    parameter int HALF_DIV = 2,
    parameter int WORD_W   = c_WORD_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [WORD_W-1:0] parallel_dac_data,
    input  logic              start_flag,
    output logic              set_done,
    output logic              cs,
    output logic              series_dac_out,
    output logic              dac_clk,
    output logic              dac_work_status
);

    localparam int                 c_BIT_W    = $clog2(WORD_W);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(WORD_W - 1);

    logic [1:0]         r_state;
    // Holds the bits still to be sent; the MSB goes straight to DIN on start,
    // so only WORD_W-1 bits need storing.
    logic [WORD_W-2:0]  r_shreg;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic               r_cs;
    logic               r_dac_clk;
    logic               r_dout;
    logic               r_done;
    logic               r_busy;

    logic               w_div_en;
    logic               w_tick;

    assign w_div_en = (r_state != c_ST_IDLE);

    tlv5618_clk_div #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_div (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .i_en   (w_div_en),
        .o_tick (w_tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= c_ST_IDLE;
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_cs      <= 1'b1;
            r_dac_clk <= 1'b1;
            r_dout    <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_cs      <= 1'b1;
                    r_dac_clk <= 1'b1;
                    r_busy    <= 1'b0;
                    r_bit_cnt <= '0;
                    if (start_flag) begin
                        r_shreg   <= parallel_dac_data[WORD_W-2:0];
                        r_dout    <= parallel_dac_data[WORD_W-1];
                        r_cs      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= c_ST_SHIFT;
                    end
                end

                c_ST_SHIFT: begin
                    if (w_tick) begin
                        if (r_dac_clk) begin
                            // End of the high phase: falling edge, DAC samples DIN.
                            r_dac_clk <= 1'b0;
                        end else begin
                            // End of the low phase: rising edge, present next bit.
                            r_dac_clk <= 1'b1;
                            if (r_bit_cnt == c_LAST_BIT) begin
                                // DIN stays at bit 0 through the hold phase.
                                r_state <= c_ST_HOLD;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                                r_dout    <= r_shreg[WORD_W-2];
                                r_shreg   <= {r_shreg[WORD_W-3:0], 1'b0};
                            end
                        end
                    end
                end

                c_ST_HOLD: begin
                    // One half period of CS hold after the last rising edge.
                    if (w_tick) begin
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_cs      <= 1'b1;
                    r_dac_clk <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign set_done        = r_done;
    assign cs              = r_cs;
    assign series_dac_out  = r_dout;
    assign dac_clk         = r_dac_clk;
    assign dac_work_status = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tlv5618_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tlv5618_driver
//  Purpose  : Self-checking bench for tlv5618_driver. Two instances are run,
//             HALF_DIV = 2 and HALF_DIV = 1. A pin-level monitor plays the
//             role of the DAC: it records DIN on every dac_clk falling edge,
//             measures cs low time and SCLK period, and logs each set_done.
//             Expected frames come from the words the bench sent.
//  Revision : 1.0  initial release
// ============================================================================
import tlv5618_driver_pkg::*;

module tb_tlv5618_driver;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic [1:0]  start_v;
    logic [15:0] data0;
    logic [15:0] data1;
    logic [1:0]  done_v;
    logic [1:0]  cs_v;
    logic [1:0]  dout_v;
    logic [1:0]  dclk_v;
    logic [1:0]  busy_v;

    always #5 sys_clk = ~sys_clk;

    tlv5618_driver #(.HALF_DIV(2), .WORD_W(16)) dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .parallel_dac_data (data0),
        .start_flag        (start_v[0]),
        .set_done          (done_v[0]),
        .cs                (cs_v[0]),
        .series_dac_out    (dout_v[0]),
        .dac_clk           (dclk_v[0]),
        .dac_work_status   (busy_v[0])
    );

    tlv5618_driver #(.HALF_DIV(1), .WORD_W(16)) dut_hd1 (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .parallel_dac_data (data1),
        .start_flag        (start_v[1]),
        .set_done          (done_v[1]),
        .cs                (cs_v[1]),
        .series_dac_out    (dout_v[1]),
        .dac_clk           (dclk_v[1]),
        .dac_work_status   (busy_v[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int hd(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // ---------------- DAC-side monitor ----------------
    typedef struct {
        logic [15:0] word;
        int          bits;
        int          lows;
        logic        coinc;
    } rec_t;

    rec_t        q0[$];
    rec_t        q1[$];
    logic [15:0] rx_word [2];
    int          rx_bits [2];
    int          low_cnt [2];
    int          high_run[2];
    int          gap     [2];
    int          last_fall[2];
    logic        prev_cs  [2];
    logic        prev_dclk[2];
    logic        mon_en = 1'b0;
    int          cyc = 0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rx_word[d]   = '0;
            rx_bits[d]   = 0;
            low_cnt[d]   = 0;
            high_run[d]  = 0;
            gap[d]       = 0;
            last_fall[d] = 0;
            prev_cs[d]   = 1'b1;
            prev_dclk[d] = 1'b1;
        end
    end

    always @(negedge sys_clk) begin : mon
        rec_t r;
        cyc++;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("status_eq_ncs%0d", d), busy_v[d], !cs_v[d]);
                if (prev_cs[d] && !cs_v[d]) begin
                    gap[d]     = high_run[d];
                    rx_word[d] = '0;
                    rx_bits[d] = 0;
                    low_cnt[d] = 0;
                end
                if (cs_v[d]) begin
                    high_run[d]++;
                end else begin
                    high_run[d] = 0;
                    low_cnt[d]++;
                end
                if (prev_dclk[d] && !dclk_v[d]) begin
                    check($sformatf("fall_inside_cs%0d", d), cs_v[d], 0);
                    if (rx_bits[d] > 0)
                        check($sformatf("sclk_period%0d", d), cyc - last_fall[d], 2 * hd(d));
                    last_fall[d] = cyc;
                    rx_word[d]   = {rx_word[d][14:0], dout_v[d]};
                    rx_bits[d]++;
                end
                if (done_v[d]) begin
                    r.word  = rx_word[d];
                    r.bits  = rx_bits[d];
                    r.lows  = low_cnt[d];
                    r.coinc = cs_v[d] && !prev_cs[d];
                    if (d == 0) q0.push_back(r);
                    else        q1.push_back(r);
                end
                prev_cs[d]   = cs_v[d];
                prev_dclk[d] = dclk_v[d];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int d, input logic [15:0] w);
        @(negedge sys_clk);
        start_v[d] = 1'b1;
        if (d == 0) data0 = w;
        else        data1 = w;
        @(negedge sys_clk);
        start_v[d] = 1'b0;
        // Scramble the data bus: the driver must have latched the word already.
        if (d == 0) data0 = 16'($urandom);
        else        data1 = 16'($urandom);
    endtask

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    // Reference: every accepted word comes back verbatim as 16 sampled bits,
    // with cs low for 33 half periods and set_done on the cs rising edge.
    task automatic expect_rec(input int d, input logic [15:0] w, input string tag);
        rec_t r;
        int   waited;
        waited = 0;
        while (qsize(d) == 0 && waited < 400) begin
            @(negedge sys_clk);
            waited++;
        end
        if (qsize(d) == 0) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            if (d == 0) r = q0.pop_front();
            else        r = q1.pop_front();
            check({tag, "_word"},  r.word, w);
            check({tag, "_bits"},  r.bits, 16);
            check({tag, "_cslow"}, r.lows, 33 * hd(d));
            check({tag, "_done_at_cs_rise"}, r.coinc, 1);
        end
    endtask

    task automatic expect_quiet(input int d, input string tag);
        repeat (4) @(negedge sys_clk);
        check({tag, "_cs_idle"}, cs_v[d], 1);
        check({tag, "_no_extra_done"}, qsize(d), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] w;
        int          k;

        sys_rst = 1'b1;
        start_v = 2'b00;
        data0   = '0;
        data1   = '0;

        repeat (6) @(negedge sys_clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_cs%0d", d),   cs_v[d],   1);
            check($sformatf("rst_dclk%0d", d), dclk_v[d], 1);
            check($sformatf("rst_dout%0d", d), dout_v[d], 0);
            check($sformatf("rst_done%0d", d), done_v[d], 0);
            check($sformatf("rst_busy%0d", d), busy_v[d], 0);
        end
        mon_en  = 1'b1;
        sys_rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        // Single transfer.
        send(0, 16'hA5C3);
        expect_rec(0, 16'hA5C3, "single");
        expect_quiet(0, "single");

        // Second start pulse 20 cycles into a transfer is ignored.
        send(0, 16'h3C96);
        repeat (19) @(negedge sys_clk);
        start_v[0] = 1'b1;
        data0      = 16'hFFFF;
        @(negedge sys_clk);
        start_v[0] = 1'b0;
        expect_rec(0, 16'h3C96, "busy20");
        expect_quiet(0, "busy20");

        // Start pulse landing exactly on the set_done edge is ignored too.
        send(0, 16'h6E01);
        repeat (65) @(negedge sys_clk);
        start_v[0] = 1'b1;
        data0      = 16'h0F0F;
        @(negedge sys_clk);
        start_v[0] = 1'b0;
        expect_rec(0, 16'h6E01, "busy_done_edge");
        expect_quiet(0, "busy_done_edge");

        // Back-to-back transfers with start held high.
        @(negedge sys_clk);
        start_v[0] = 1'b1;
        data0      = make_word(c_CTRL_DAC_A_FAST, 12'h800);
        @(negedge sys_clk);
        data0      = 16'h4FFF;
        expect_rec(0, 16'hC800, "b2b_first");
        repeat (5) @(negedge sys_clk);
        start_v[0] = 1'b0;
        data0      = 16'h1234;
        expect_rec(0, 16'h4FFF, "b2b_second");
        check("b2b_cs_high_gap", gap[0], 1);
        expect_quiet(0, "b2b");

        // Reset during bit 7 aborts without set_done.
        send(0, 16'h5A5A);
        repeat (29) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("midrst_cs",   cs_v[0],   1);
        check("midrst_dclk", dclk_v[0], 1);
        check("midrst_busy", busy_v[0], 0);
        check("midrst_done", done_v[0], 0);
        sys_rst = 1'b0;
        expect_quiet(0, "midrst");
        send(0, 16'h0001);
        expect_rec(0, 16'h0001, "after_rst");
        expect_quiet(0, "after_rst");

        // Randomized words with optional ignored start pulses while busy.
        for (int i = 0; i < 10; i++) begin
            w = 16'($urandom);
            k = $urandom_range(1, 65);
            send(0, w);
            if ($urandom_range(0, 1) == 1) begin
                repeat (k) @(negedge sys_clk);
                start_v[0] = 1'b1;
                data0      = 16'($urandom);
                @(negedge sys_clk);
                start_v[0] = 1'b0;
            end
            expect_rec(0, w, "rand");
            expect_quiet(0, "rand");
        end

        // HALF_DIV = 1 instance.
        send(1, 16'hFFFF);
        expect_rec(1, 16'hFFFF, "hd1_ffff");
        expect_quiet(1, "hd1_ffff");
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom);
            send(1, w);
            expect_rec(1, w, "hd1_rand");
            expect_quiet(1, "hd1_rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
